// File: rtl/ladybird_uart_loader_if.sv
// Word-write bus between the UART loader (primary) and the memory it fills.
// A write is held on req/addr/wstrb/data until the edge where req && gnt.
interface ladybird_bus;
    logic        req;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] data;
    logic        gnt;

    modport primary   (output req, addr, wstrb, data, input gnt);
    modport secondary (input req, addr, wstrb, data, output gnt);
endinterface

// File: rtl/ladybird_uart_loader.sv
// UART program loader: receives a little-endian word count followed by that
// many little-endian words over 8N1 serial, and writes each word to
// consecutive addresses starting at BASE_ADDR.
//
// RX FSM
//   state   | meaning
//   R_IDLE  | line idle, waiting for a synchronized falling edge
//   R_START | timing to mid start bit; a high line there is a glitch
//   R_DATA  | sampling 8 data bits, LSB first, one per bit period
//   R_STOP  | sampling the stop bit; low is a framing error
//
// Loader FSM
//   state   | meaning
//   L_LEN   | assembling the 32-bit word count
//   L_DATA  | assembling the next program word
//   L_WRITE | bus write pending; next word keeps assembling meanwhile
//   L_DONE  | all words granted; absorbing until reset
//   L_ERR   | bad length, framing error or overrun; absorbing until reset
module ladybird_uart_loader #(
    parameter int          CLK_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MAX_WORDS   = 8
) (
    input  logic        clk,
    input  logic        anrst,
    input  logic        uart_txd_in,
    ladybird_bus.primary bus,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    localparam int TW = $clog2(CLK_PER_BIT + 1);
    localparam logic [TW-1:0] FULL_TC = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_TC = TW'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_LEN, L_DATA, L_WRITE, L_DONE, L_ERR} ld_state_t;

    logic            rx_meta, rx_sync, rx_prev;
    rx_state_t       rx_state, rx_state_d;
    logic [TW-1:0]   rx_timer, rx_timer_d;
    logic [2:0]      rx_bit, rx_bit_d;
    logic [7:0]      rx_shift, rx_shift_d;
    logic            byte_stb, byte_stb_d;
    logic            frame_err, frame_err_d;

    ld_state_t       l_state, l_state_d;
    logic [31:0]     len_q, len_d;
    logic [31:0]     asm_q, asm_d;
    logic [1:0]      bcnt, bcnt_d;
    logic [15:0]     ww_q, ww_d;
    logic            req_q, req_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [31:0]     data_q, data_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic [31:0]     word_full;
    logic            last_byte;
    logic            granted;
    logic            finishing;

    // Two-flop synchronizer plus edge-detect history; idle level is high so
    // reset release never looks like a start bit.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_txd_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX state register and bit-timing datapath.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            rx_state  <= R_IDLE;
            rx_timer  <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_state_d;
            rx_timer  <= rx_timer_d;
            rx_bit    <= rx_bit_d;
            rx_shift  <= rx_shift_d;
            byte_stb  <= byte_stb_d;
            frame_err <= frame_err_d;
        end
    end

    // RX next state: down-counting bit timer, sample on terminal count.
    always_comb begin
        rx_state_d  = rx_state;
        rx_timer_d  = rx_timer;
        rx_bit_d    = rx_bit;
        rx_shift_d  = rx_shift;
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_d = R_START;
                    rx_timer_d = HALF_TC;
                end
            end
            R_START: begin
                if (rx_timer == '0) begin
                    if (rx_sync) begin
                        rx_state_d = R_IDLE;
                    end else begin
                        rx_state_d = R_DATA;
                        rx_timer_d = FULL_TC;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_timer_d = rx_timer - TW'(1);
                end
            end
            R_DATA: begin
                if (rx_timer == '0) begin
                    rx_shift_d = {rx_sync, rx_shift[7:1]};
                    rx_timer_d = FULL_TC;
                    if (rx_bit == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        rx_bit_d = rx_bit + 3'd1;
                    end
                end else begin
                    rx_timer_d = rx_timer - TW'(1);
                end
            end
            R_STOP: begin
                if (rx_timer == '0) begin
                    rx_state_d = R_IDLE;
                    if (rx_sync) begin
                        byte_stb_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    rx_timer_d = rx_timer - TW'(1);
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // Loader state register and all registered outputs.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            l_state <= L_LEN;
            len_q   <= '0;
            asm_q   <= '0;
            bcnt    <= '0;
            ww_q    <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            l_state <= l_state_d;
            len_q   <= len_d;
            asm_q   <= asm_d;
            bcnt    <= bcnt_d;
            ww_q    <= ww_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            data_q  <= data_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign word_full = {rx_shift, asm_q[31:8]};
    assign last_byte = byte_stb && (bcnt == 2'd3);
    assign granted   = req_q && bus.gnt;
    assign finishing = (({16'd0, ww_q} + 32'd1) == len_q);

    // Loader next state: byte assembly, length check, write handshake.
    always_comb begin
        l_state_d = l_state;
        len_d     = len_q;
        asm_d     = asm_q;
        bcnt_d    = bcnt;
        ww_d      = ww_q;
        req_d     = req_q;
        addr_d    = addr_q;
        wstrb_d   = wstrb_q;
        data_d    = data_q;
        if (frame_err && l_state != L_DONE && l_state != L_ERR) begin
            l_state_d = L_ERR;
            req_d     = 1'b0;
        end else begin
            case (l_state)
                L_LEN: begin
                    if (byte_stb) begin
                        asm_d  = word_full;
                        bcnt_d = bcnt + 2'd1;
                        if (last_byte) begin
                            len_d = word_full;
                            if (word_full == 32'd0)
                                l_state_d = L_DONE;
                            else if (word_full > 32'(MAX_WORDS))
                                l_state_d = L_ERR;
                            else
                                l_state_d = L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    if (byte_stb) begin
                        asm_d  = word_full;
                        bcnt_d = bcnt + 2'd1;
                        if (last_byte) begin
                            req_d     = 1'b1;
                            addr_d    = BASE_ADDR + {14'd0, ww_q, 2'b00};
                            wstrb_d   = 4'hF;
                            data_d    = word_full;
                            l_state_d = L_WRITE;
                        end
                    end
                end
                L_WRITE: begin
                    if (byte_stb) begin
                        asm_d  = word_full;
                        bcnt_d = bcnt + 2'd1;
                    end
                    if (granted) begin
                        req_d = 1'b0;
                        ww_d  = ww_q + 16'd1;
                        if (finishing) begin
                            l_state_d = L_DONE;
                        end else if (last_byte) begin
                            // Next word landed on the grant edge: start it.
                            req_d   = 1'b1;
                            addr_d  = BASE_ADDR + {14'd0, ww_q + 16'd1, 2'b00};
                            wstrb_d = 4'hF;
                            data_d  = word_full;
                        end else begin
                            l_state_d = L_DATA;
                        end
                    end else if (last_byte) begin
                        l_state_d = L_ERR;
                        req_d     = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        done_d  = (l_state_d == L_DONE);
        error_d = (l_state_d == L_ERR);
    end

    assign bus.req       = req_q;
    assign bus.addr      = addr_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.data      = data_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_ladybird_uart_loader.sv
// Bench for the UART loader: directed serial streams, a queue of expected
// writes, and a per-cycle monitor on the bus handshake and counters.
module tb_ladybird_uart_loader;

    localparam int CPB = 16;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        anrst = 1'b0;
    logic        txd = 1'b1;
    logic        done, error;
    logic [15:0] ww;

    ladybird_bus bus_if ();

    ladybird_uart_loader #(
        .CLK_PER_BIT(CPB),
        .BASE_ADDR  (32'h0000_0000),
        .MAX_WORDS  (8)
    ) dut (
        .clk          (clk),
        .anrst        (anrst),
        .uart_txd_in  (txd),
        .bus          (bus_if),
        .done         (done),
        .error        (error),
        .words_written(ww)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    wr_t exp_q[$];
    int gnt_mode = 0;   // 0: always granted, 1: 40-cycle stall, 2: never
    int grants   = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    logic [31:0] prog [5] = '{32'hFFFFF0B7, 32'h0000A103, 32'h00110113,
                              32'h0020A023, 32'hFF5FF0EF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant responder.
    initial begin
        int stall;
        stall = 0;
        bus_if.gnt = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt_mode == 0) begin
                bus_if.gnt = 1'b1;
            end else if (gnt_mode == 1) begin
                if (!bus_if.req) begin
                    stall = 0;
                    bus_if.gnt = 1'b0;
                end else if (stall >= 40) begin
                    bus_if.gnt = 1'b1;
                end else begin
                    stall++;
                    bus_if.gnt = 1'b0;
                end
            end else begin
                bus_if.gnt = 1'b0;
            end
        end
    end

    // Per-cycle monitor against the expected-write queue.
    initial begin
        logic        p_req, p_gnt;
        logic [31:0] p_addr, p_data;
        logic [3:0]  p_wstrb;
        wr_t         e;
        p_req = 1'b0; p_gnt = 1'b0; p_addr = '0; p_data = '0; p_wstrb = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!anrst) begin
                grants = 0;
                p_req  = 1'b0;
                p_gnt  = 1'b0;
            end else begin
                check("words_written", {16'd0, ww}, grants);
                if (done || error) check("req_after_end", bus_if.req, 1'b0);
                if (p_req && p_gnt) check("req_after_grant", bus_if.req, 1'b0);
                if (p_req && !p_gnt && !error) begin
                    check("stall_req", bus_if.req, 1'b1);
                    check("stall_addr", bus_if.addr, p_addr);
                    check("stall_data", bus_if.data, p_data);
                    check("stall_wstrb", {28'd0, bus_if.wstrb}, {28'd0, p_wstrb});
                end
                if (bus_if.req && bus_if.gnt) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                                 bus_if.addr, bus_if.data);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", bus_if.addr, e.addr);
                        check("write_data", bus_if.data, e.data);
                        check("write_wstrb", {28'd0, bus_if.wstrb}, 32'hF);
                    end
                    last_addr = bus_if.addr;
                    last_data = bus_if.data;
                    grants++;
                end
                p_req   = bus_if.req;
                p_gnt   = bus_if.gnt;
                p_addr  = bus_if.addr;
                p_data  = bus_if.data;
                p_wstrb = bus_if.wstrb;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        anrst = 1'b0;
        txd   = 1'b1;
        exp_q.delete();
        repeat (4) @(negedge clk);
        check("rst_req", bus_if.req, 1'b0);
        check("rst_addr", bus_if.addr, 32'h0);
        check("rst_data", bus_if.data, 32'h0);
        check("rst_wstrb", {28'd0, bus_if.wstrb}, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_ww", {16'd0, ww}, 32'h0);
        anrst = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        txd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            txd = b[i];
            repeat (CPB) @(negedge clk);
        end
        txd = stop;
        repeat (CPB) @(negedge clk);
        txd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    // bad_byte selects a byte whose stop bit is forced low (-1 for none).
    task automatic send_word(input logic [31:0] w, input int bad_byte);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], (i != bad_byte));
    endtask

    task automatic wait_flag(input string name, input bit want_done, input int limit);
        int n;
        n = 0;
        while (!(want_done ? done : error) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, want_done ? done : error, 1'b1);
    endtask

    task automatic push_prog(input int count);
        wr_t e;
        for (int i = 0; i < count; i++) begin
            e.addr = 32'(4 * i);
            e.data = prog[i];
            exp_q.push_back(e);
        end
    endtask

    initial begin
        wr_t e;

        // Five-word load, grant always high.
        gnt_mode = 0;
        do_reset();
        push_prog(5);
        send_word(32'd5, -1);
        for (int i = 0; i < 5; i++) send_word(prog[i], -1);
        wait_flag("t1_done", 1'b1, 2000);
        check("t1_ww", {16'd0, ww}, 32'd5);
        check("t1_error", error, 1'b0);
        check("t1_pending", exp_q.size(), 0);
        check("t1_last_addr", last_addr, 32'h0000_0010);
        check("t1_last_data", last_data, 32'hFF5FF0EF);

        // Same stream, each write stalled 40 cycles.
        gnt_mode = 1;
        do_reset();
        push_prog(5);
        send_word(32'd5, -1);
        for (int i = 0; i < 5; i++) send_word(prog[i], -1);
        wait_flag("t2_done", 1'b1, 2000);
        check("t2_ww", {16'd0, ww}, 32'd5);
        check("t2_pending", exp_q.size(), 0);
        check("t2_last_addr", last_addr, 32'h0000_0010);

        // Zero length.
        gnt_mode = 0;
        do_reset();
        send_word(32'd0, -1);
        check("t3_done", done, 1'b1);
        check("t3_ww", {16'd0, ww}, 32'd0);
        send_byte(8'hA5, 1'b1);
        check("t3_done_hold", done, 1'b1);

        // Length over the limit, then a clean one-word load.
        do_reset();
        send_word(32'd9, -1);
        wait_flag("t4_error", 1'b0, 200);
        check("t4_done", done, 1'b0);
        do_reset();
        e.addr = 32'h0;
        e.data = 32'h1234_5678;
        exp_q.push_back(e);
        send_word(32'd1, -1);
        send_word(32'h1234_5678, -1);
        wait_flag("t4_done_after", 1'b1, 200);
        check("t4_ww", {16'd0, ww}, 32'd1);
        check("t4_last_data", last_data, 32'h1234_5678);

        // Framing error in the second data word.
        do_reset();
        push_prog(1);
        send_word(32'd2, -1);
        send_word(prog[0], -1);
        send_word(prog[1], 1);
        wait_flag("t5_error", 1'b0, 200);
        check("t5_ww", {16'd0, ww}, 32'd1);
        send_word(prog[2], -1);
        check("t5_error_hold", error, 1'b1);
        check("t5_req", bus_if.req, 1'b0);
        check("t5_ww_hold", {16'd0, ww}, 32'd1);

        // Grant withheld past a word time: overrun.
        gnt_mode = 2;
        do_reset();
        send_word(32'd2, -1);
        send_word(prog[0], -1);
        send_word(prog[1], -1);
        wait_flag("t6_error", 1'b0, 200);
        check("t6_ww", {16'd0, ww}, 32'd0);
        check("t6_req", bus_if.req, 1'b0);

        // Short low glitch on an idle line yields no byte.
        gnt_mode = 0;
        do_reset();
        txd = 1'b0;
        repeat (4) @(negedge clk);
        txd = 1'b1;
        repeat (100) @(negedge clk);
        send_word(32'd0, -1);
        check("t7_done", done, 1'b1);
        check("t7_error", error, 1'b0);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ladybird_uart_loader.md
LADYBIRD_UART_LOADER -- requirements
Module: ladybird_uart_loader

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, UART bit period in clk cycles (100 MHz / 115200); legal range >= 8.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written.
REQ-003 SHALL have parameter MAX_WORDS, default 8, largest accepted program length in words.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port anrst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port uart_txd_in, input, 1 bit: UART serial in, 8N1, LSB first, asynchronous to clk.
REQ-007 SHALL have port bus, ladybird_bus primary modport: req, addr[31:0], wstrb[3:0] and data[31:0] out; gnt in.
REQ-008 SHALL have port done, output, 1 bit: program fully written.
REQ-009 SHALL have port error, output, 1 bit: load aborted.
REQ-010 SHALL have port words_written, output, 16 bits: count of granted word writes.

Function
REQ-011 SHALL pass uart_txd_in through a 2-flop synchronizer before any use.
REQ-012 SHALL run UART RX states R_IDLE, R_START, R_DATA, R_STOP.
REQ-013 SHALL move R_IDLE->R_START on a synchronized 1->0 transition.
REQ-014 SHALL, in R_START, resample at CLK_PER_BIT/2 cycles; if the line is high, return to R_IDLE (glitch, no byte); else go to R_DATA.
REQ-015 SHALL, in R_DATA, sample 8 bits one every CLK_PER_BIT cycles, LSB first.
REQ-016 SHALL, in R_STOP, sample once; line=1 delivers the byte as a 1-cycle byte strobe; line=0 is a framing error.
REQ-017 SHALL run loader states L_LEN, L_DATA, L_WRITE, L_DONE, L_ERR.
REQ-018 SHALL, in L_LEN, assemble 4 bytes little-endian into a 32-bit length N.
REQ-019 SHALL, on the 4th length byte, go to L_DONE if N==0, L_ERR if N>MAX_WORDS, else L_DATA.
REQ-020 SHALL, in L_DATA, assemble 4 bytes little-endian into a word; the 4th byte loads the write register and enters L_WRITE.
REQ-021 SHALL, on entering L_WRITE, register req=1, addr=BASE_ADDR+4*words_written, wstrb=4'hF and data=word.
REQ-022 SHALL hold req, addr, wstrb and data stable until the first rising edge with req&&gnt sampled high.
REQ-023 SHALL, on that grant edge, clear req in the same edge, increment words_written, and go to L_DONE if words_written+1==N, else L_DATA.
REQ-024 SHALL never keep req high for a cycle after its grant; one transaction per assembled word.
REQ-025 SHALL keep assembling bytes of the next word in L_WRITE; a word that completes while the prior write is ungranted SHALL go to L_ERR (overrun).
REQ-026 SHALL go to L_ERR from any loader state except L_DONE on a framing error.
REQ-027 SHALL keep L_DONE and L_ERR absorbing until reset, ignore all further bytes there, and never raise req there.
REQ-028 SHALL drive done=1 exactly in L_DONE and error=1 exactly in L_ERR, both registered.
REQ-029 SHALL register every output; no combinational path from gnt or uart_txd_in to any output.

Reset
REQ-030 SHALL, on anrst=0 and asynchronously, force R_IDLE, L_LEN, req=0, addr=0, wstrb=0, data=0, done=0, error=0, words_written=0, and clear the length, word and byte counters.
REQ-031 SHALL treat the synchronizer reset value as 1 (line idle), so release of reset with the line high creates no start bit.
REQ-032 SHALL, when reset is asserted mid-transfer or mid-write, drop req immediately; after reset release, reload from the length field.

Verification (CLK_PER_BIT=16, BASE_ADDR=0, MAX_WORDS=8)
REQ-033 SHALL cover: send length 5 and words 0xFFFFF0B7, 0x0000A103, 0x00110113, 0x0020A023, 0xFF5FF0EF with gnt tied high -> 5 writes to 0x00,0x04,...,0x10 with those data and wstrb=F, then done=1 and words_written=5.
REQ-034 SHALL cover: same stream with gnt held low 40 cycles per write -> req and addr/data stable throughout each stall, identical write sequence, done=1.
REQ-035 SHALL cover: length 0 -> done=1 after 4th length byte, req never asserted.
REQ-036 SHALL cover: length 9 -> error=1, no req; then a 1-word load after reset completes normally.
REQ-037 SHALL cover: a stop bit forced to 0 in the 2nd data word -> error=1, words_written=1, req low thereafter.
REQ-038 SHALL cover: gnt low for longer than one word time -> error=1 (overrun); a 4-cycle low glitch on an idle line -> no byte received.
